// File: rtl/algo_nr1w_dup_fwd.sv
// algo_nr1w_dup_fwd: N-read 1-write memory from duplicated 1R1W copies with same-cycle write forwarding and parity check
module algo_nr1w_dup_fwd #(
  parameter int WIDTH      = 32,
  parameter int NUMADDR    = 1024,
  parameter int BITADDR    = 10,
  parameter int NUMRDPT    = 4,
  parameter int SRAM_DELAY = 2,
  parameter int ENAPAR     = 1,
  parameter int MEMWDTH    = WIDTH + ENAPAR
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready,
  input  logic                       write,
  input  logic [BITADDR-1:0]         wr_adr,
  input  logic [WIDTH-1:0]           din,
  input  logic [NUMRDPT-1:0]         read,
  input  logic [NUMRDPT*BITADDR-1:0] rd_adr,
  output logic [NUMRDPT-1:0]         rd_vld,
  output logic [NUMRDPT*WIDTH-1:0]   rd_dout,
  output logic [NUMRDPT-1:0]         rd_fwrd,
  output logic [NUMRDPT-1:0]         rd_serr,
  output logic [15:0]                err_cnt,
  output logic [NUMRDPT-1:0]         t1_writeA,
  output logic [NUMRDPT*BITADDR-1:0] t1_addrA,
  output logic [NUMRDPT*MEMWDTH-1:0] t1_dinA,
  output logic [NUMRDPT-1:0]         t1_readB,
  output logic [NUMRDPT*BITADDR-1:0] t1_addrB,
  input  logic [NUMRDPT*MEMWDTH-1:0] t1_doutB
);
  localparam logic [0:0] INIT  = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  logic [0:0]         state;
  logic [BITADDR-1:0] icnt;
  logic [NUMRDPT-1:0] vld_q [SRAM_DELAY];
  logic [NUMRDPT-1:0] fwd_q [SRAM_DELAY];
  logic [WIDTH-1:0]   din_q [SRAM_DELAY];
  logic [NUMRDPT-1:0] rd_acc, hit;
  logic [MEMWDTH-1:0] wword;
  logic [16:0]        esum;
  assign ready = state == READY;
  // Copy write/read port steering, forwarded-data select, parity check and error accumulation
  always_comb begin
    wword = MEMWDTH'({1'(ENAPAR) & ^din, din});
    esum  = {1'b0, err_cnt};
    for (int p = 0; p < NUMRDPT; p++) begin
      rd_acc[p] = ready & read[p];
      hit[p] = rd_acc[p] & write & (wr_adr == rd_adr[p*BITADDR +: BITADDR]);
      t1_writeA[p] = !ready | write;
      t1_addrA[p*BITADDR +: BITADDR] = ready ? wr_adr : icnt;
      t1_dinA[p*MEMWDTH +: MEMWDTH] = ready ? wword : '0;
      t1_readB[p] = rd_acc[p];
      t1_addrB[p*BITADDR +: BITADDR] = rd_adr[p*BITADDR +: BITADDR];
      rd_vld[p] = vld_q[SRAM_DELAY-1][p];
      rd_fwrd[p] = rd_vld[p] & fwd_q[SRAM_DELAY-1][p];
      rd_dout[p*WIDTH +: WIDTH] = !rd_vld[p] ? '0 : rd_fwrd[p] ? din_q[SRAM_DELAY-1] : t1_doutB[p*MEMWDTH +: WIDTH];
      rd_serr[p] = rd_vld[p] & !rd_fwrd[p] & (ENAPAR != 0) & ^t1_doutB[p*MEMWDTH +: MEMWDTH];
      esum = esum + 17'(rd_serr[p]);
    end
  end
  // Init sweep, read-latency and forwarding pipelines, saturating error counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= INIT;
      icnt    <= '0;
      err_cnt <= '0;
      for (int i = 0; i < SRAM_DELAY; i++) begin
        vld_q[i] <= '0;
        fwd_q[i] <= '0;
        din_q[i] <= '0;
      end
    end else begin
      if (state == INIT) begin
        icnt <= icnt + BITADDR'(1);
        if (icnt == BITADDR'(NUMADDR - 1)) state <= READY;
      end
      vld_q[0] <= rd_acc;
      fwd_q[0] <= hit;
      din_q[0] <= din;
      for (int i = 1; i < SRAM_DELAY; i++) begin
        vld_q[i] <= vld_q[i-1];
        fwd_q[i] <= fwd_q[i-1];
        din_q[i] <= din_q[i-1];
      end
      err_cnt <= esum[16] ? 16'hFFFF : esum[15:0];
    end
  end
endmodule

// File: tb/tb_algo_nr1w_dup_fwd.sv
// tb_algo_nr1w_dup_fwd: randomized and directed check of the duplicated-copy N-read memory against a logical memory model
module tb_algo_nr1w_dup_fwd;
  localparam int W = 32, NA = 1024, BA = 10, NP = 4, D = 2, MW = W + 1;
  logic clk = 0, rst = 0, ready, write = 0;
  logic [BA-1:0] wr_adr = 0;
  logic [W-1:0] din = 0;
  logic [NP-1:0] read = 0, rd_vld, rd_fwrd, rd_serr, t1_writeA, t1_readB;
  logic [NP*BA-1:0] rd_adr = 0, t1_addrA, t1_addrB;
  logic [NP*W-1:0] rd_dout;
  logic [15:0] err_cnt;
  logic [NP*MW-1:0] t1_dinA, t1_doutB;
  logic flip_en = 0;
  int flip_c = 0, flip_a = 0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  algo_nr1w_dup_fwd #(.WIDTH(W), .NUMADDR(NA), .BITADDR(BA), .NUMRDPT(NP), .SRAM_DELAY(D), .ENAPAR(1)) dut (
    .clk(clk), .rst(rst), .ready(ready), .write(write), .wr_adr(wr_adr), .din(din),
    .read(read), .rd_adr(rd_adr), .rd_vld(rd_vld), .rd_dout(rd_dout), .rd_fwrd(rd_fwrd),
    .rd_serr(rd_serr), .err_cnt(err_cnt), .t1_writeA(t1_writeA), .t1_addrA(t1_addrA),
    .t1_dinA(t1_dinA), .t1_readB(t1_readB), .t1_addrB(t1_addrB), .t1_doutB(t1_doutB));
  // SRAM copies: read returns pre-write contents, D cycles after the request
  logic [MW-1:0] mem [NP][NA];
  logic [MW-1:0] pipe [NP][D];
  always @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      for (int i = D - 1; i > 0; i--) pipe[p][i] <= pipe[p][i-1];
      pipe[p][0] <= t1_readB[p] ? mem[p][t1_addrB[p*BA +: BA]] : '0;
      if (t1_writeA[p]) mem[p][t1_addrA[p*BA +: BA]] <= t1_dinA[p*MW +: MW];
    end
    if (flip_en) mem[flip_c][flip_a][0] <= ~mem[flip_c][flip_a][0];
  end
  always_comb for (int p = 0; p < NP; p++) t1_doutB[p*MW +: MW] = pipe[p][D-1];
  // Behavioural model: logical memory, per-copy corruption masks, expectation slots keyed by due cycle
  logic [W-1:0] lm [NA];
  logic [MW-1:0] xm [NP][NA];
  logic ev [8][NP], ef [8][NP], es [8][NP];
  logic [W-1:0] ed [8][NP];
  int cyc = 0, since = 0, exp_err = 0;
  always @(posedge clk) begin
    int s, a;
    bit acc;
    cyc++;
    s = (cyc + D - 1) % 8;
    for (int p = 0; p < NP; p++) begin ev[s][p] = 0; ef[s][p] = 0; es[s][p] = 0; ed[s][p] = 0; end
    if (!rst) begin
      since = 0;
      for (int i = 0; i < NA; i++) begin
        lm[i] = 0;
        for (int p = 0; p < NP; p++) xm[p][i] = 0;
      end
    end else begin
      acc = since >= NA;
      since++;
      for (int p = 0; p < NP; p++) if (acc && read[p]) begin
        a = int'(rd_adr[p*BA +: BA]);
        ev[s][p] = 1;
        if (write && int'(wr_adr) == a) begin ed[s][p] = din; ef[s][p] = 1; end
        else begin ed[s][p] = lm[a] ^ xm[p][a][W-1:0]; es[s][p] = ^xm[p][a]; end
      end
      if (acc && write) begin
        lm[wr_adr] = din;
        for (int p = 0; p < NP; p++) xm[p][wr_adr] = 0;
      end
      if (flip_en) xm[flip_c][flip_a][0] = ~xm[flip_c][flip_a][0];
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  // Per-cycle comparison of every read-side output against the model
  always @(negedge clk) begin
    int s, n;
    if (!rst) begin
      exp_err = 0;
      chk("rst_ready", ready, 0);
      chk("rst_vld", rd_vld, 0);
      chk("rst_fwrd", rd_fwrd, 0);
      chk("rst_serr", rd_serr, 0);
      chk("rst_err_cnt", err_cnt, 0);
    end else begin
      s = cyc % 8;
      n = 0;
      chk("ready", ready, since >= NA);
      chk("err_cnt", err_cnt, exp_err);
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("vld%0d", p), rd_vld[p], ev[s][p]);
        chk($sformatf("dout%0d", p), rd_dout[p*W +: W], ev[s][p] ? ed[s][p] : 0);
        chk($sformatf("fwrd%0d", p), rd_fwrd[p], ev[s][p] & ef[s][p]);
        chk($sformatf("serr%0d", p), rd_serr[p], ev[s][p] & es[s][p]);
        n += int'(ev[s][p] & es[s][p]);
      end
      exp_err = (exp_err + n > 65535) ? 65535 : exp_err + n;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_adr(input int a);
    for (int p = 0; p < NP; p++) rd_adr[p*BA +: BA] = BA'(a);
  endtask
  task automatic wait_ready(input bit rnd);
    int n = 0;
    while (!ready && n < 2000) begin
      if (rnd) begin read = NP'($urandom); rd_adr = NP*BA'({$urandom, $urandom}); end
      tick();
      n++;
    end
    read = 0;
    chk("ready_cycle", n, NA);
  endtask
  task automatic drain();
    read = 0;
    write = 0;
    repeat (D + 2) tick();
    @(negedge clk);
  endtask
  task automatic flip(input int c, input int a);
    flip_en = 1; flip_c = c; flip_a = a;
    tick();
    flip_en = 0;
  endtask
  task automatic rand_phase(input int n);
    repeat (n) begin
      write = 1'($urandom);
      wr_adr = BA'($urandom_range(0, 15));
      din = $urandom;
      read = NP'($urandom);
      for (int p = 0; p < NP; p++) rd_adr[p*BA +: BA] = BA'($urandom_range(0, 15));
      tick();
    end
    drain();
  endtask
  initial begin
    int rem, k;
    repeat (3) tick();
    rst = 1;
    wait_ready(0);
    set_adr(5); read = '1;
    tick(); read = 0;
    repeat (D - 1) tick();
    @(negedge clk);
    chk("init_vld", rd_vld, 4'hF);
    chk("init_dout", rd_dout, 0);
    chk("init_serr", rd_serr, 0);
    tick();
    write = 1; wr_adr = 7; din = 32'hDEADBEEF;
    tick(); write = 0;
    set_adr(7); read = '1;
    tick(); read = 0;
    repeat (D - 1) tick();
    @(negedge clk);
    chk("wr7_vld", rd_vld, 4'hF);
    chk("wr7_dout", rd_dout, {4{32'hDEADBEEF}});
    chk("wr7_fwrd", rd_fwrd, 0);
    tick();
    write = 1; wr_adr = 9; din = 32'h12345678; set_adr(9); read = 4'b0100;
    tick(); write = 0; read = 0;
    repeat (D - 1) tick();
    @(negedge clk);
    chk("fwd_vld", rd_vld, 4'b0100);
    chk("fwd_dout", rd_dout[2*W +: W], 32'h12345678);
    chk("fwd_fwrd", rd_fwrd, 4'b0100);
    chk("fwd_serr", rd_serr, 0);
    tick();
    flip(1, 3);
    set_adr(3); read = 4'b0010;
    tick(); read = 0;
    repeat (D - 1) tick();
    @(negedge clk);
    chk("par_serr", rd_serr, 4'b0010);
    chk("par_dout", rd_dout[W +: W], 32'h1);
    tick();
    @(negedge clk);
    chk("par_cnt", err_cnt, 16'h1);
    tick();
    flip(0, 3); flip(2, 3); flip(3, 3);
    set_adr(3); read = '1;
    repeat (16370) tick();
    drain();
    rem = 16'hFFFE - exp_err;
    while (rem > 0) begin
      k = rem > 4 ? 4 : rem;
      read = NP'((1 << k) - 1);
      tick();
      rem -= k;
    end
    drain();
    chk("sat_fffe", err_cnt, 16'hFFFE);
    tick();
    read = 4'b0011;
    tick();
    drain();
    chk("sat_ffff", err_cnt, 16'hFFFF);
    tick();
    read = '1;
    tick();
    drain();
    chk("sat_hold", err_cnt, 16'hFFFF);
    tick();
    rand_phase(3000);
    tick();
    read = '1;
    repeat (20) begin rd_adr = NP*BA'({$urandom, $urandom}); tick(); end
    rst = 0;
    tick(); tick();
    @(negedge clk);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_vld", rd_vld, 0);
    chk("mid_rst_err", err_cnt, 0);
    tick();
    rst = 1;
    wait_ready(1);
    rand_phase(500);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
